// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT sequencing, sequential fetch,
// PC-relative branches, absolute jumps, one-cycle flush and redirect counting.
module pc_gen #(
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch,
   input  logic              jump,
   input  logic [15:0]       imm,
   input  logic [25:0]       jtarget,
   input  logic              halt,
   input  logic              resume,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   output logic              flush,
   output logic [7:0]        redirect_cnt
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc_n;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] jmp_target;
   logic              redirect;
   logic              flush_n;
   logic [7:0]        cnt_n;

   // Offset and jump field are narrowed (or sign-extended) to the PC width,
   // so all target arithmetic wraps modulo 2^ADDR_W.
   assign pc_inc     = pc + ADDR_W'(1);
   assign br_off     = ADDR_W'($signed(imm));
   assign br_target  = pc_inc + br_off;
   assign jmp_target = ADDR_W'(jtarget);

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      redirect = 1'b0;
      case (state)
         S_BOOT: state_n = S_RUN;
         S_RUN: begin
            if (halt) begin
               state_n = S_HALT;
            end else if (stall) begin
               pc_n = pc;
            end else if (jump) begin
               pc_n     = jmp_target;
               redirect = 1'b1;
            end else if (branch) begin
               pc_n     = br_target;
               redirect = 1'b1;
            end else begin
               pc_n = pc_inc;
            end
         end
         S_HALT: begin
            if (resume && !halt) state_n = S_RUN;
         end
         default: state_n = S_BOOT;
      endcase
      flush_n = redirect;
      cnt_n   = (redirect && (redirect_cnt != 8'hFF)) ? redirect_cnt + 8'd1 : redirect_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_BOOT;
         pc           <= RESET_PC;
         flush        <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         flush        <= flush_n;
         redirect_cnt <= cnt_n;
      end
   end

   assign pc_valid = (state == S_RUN);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst, stall, branch, jump, halt, resume;
   logic [15:0] imm;
   logic [25:0] jtarget;
   logic [7:0]  pc;
   logic        pc_valid, flush;
   logic [7:0]  redirect_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  exp_cnt  = 8'd0;

   pc_gen #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump(jump),
      .imm(imm), .jtarget(jtarget), .halt(halt), .resume(resume),
      .pc(pc), .pc_valid(pc_valid), .flush(flush), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; branch = 0; jump = 0; halt = 0; resume = 0;
      imm = 16'h0000; jtarget = 26'h0;
   endtask

   task automatic bump();
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1; tick(); rst = 0;
      n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc); end
      n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", pc_valid); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush); end
      n_checks++; if (redirect_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", redirect_cnt); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (pc !== 8'(i)) begin n_fail++; $display("FAIL idle_pc[%0d] got %0d exp %0d", i, pc, i); end
         n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL idle_valid[%0d] got %b exp 1", i, pc_valid); end
      end
      n_checks++; if (redirect_cnt !== 8'd0) begin n_fail++; $display("FAIL idle_cnt got %0d exp 0", redirect_cnt); end
   endtask

   task automatic test_wrap();
      jump = 1; jtarget = 26'd255; tick(); clear_inputs(); bump();
      n_checks++; if (pc !== 8'd255) begin n_fail++; $display("FAIL wrap_setup got %0d exp 255", pc); end
      tick();
      n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL wrap_pc got %0d exp 0", pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL wrap_flush got %b exp 0", flush); end
   endtask

   task automatic test_branch();
      jump = 1; jtarget = 26'd10; tick(); clear_inputs(); bump();
      branch = 1; imm = 16'hFFFC; tick(); clear_inputs(); bump();
      n_checks++; if (pc !== 8'd7) begin n_fail++; $display("FAIL br_back_pc got %0d exp 7", pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_back_flush got %b exp 1", flush); end
      n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("FAIL br_back_cnt got %0d exp %0d", redirect_cnt, exp_cnt); end
      tick();
      n_checks++; if (pc !== 8'd8) begin n_fail++; $display("FAIL br_after_pc got %0d exp 8", pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_after_flush got %b exp 0", flush); end
      jump = 1; jtarget = 26'd250; tick(); clear_inputs(); bump();
      branch = 1; imm = 16'd10; tick(); clear_inputs(); bump();
      n_checks++; if (pc !== 8'd5) begin n_fail++; $display("FAIL br_fwd_wrap got %0d exp 5", pc); end
      branch = 1; imm = 16'd0; tick(); clear_inputs(); bump();
      n_checks++; if (pc !== 8'd6) begin n_fail++; $display("FAIL br_zero_pc got %0d exp 6", pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_zero_flush got %b exp 1", flush); end
      n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("FAIL br_zero_cnt got %0d exp %0d", redirect_cnt, exp_cnt); end
   endtask

   task automatic test_jump_branch();
      jump = 1; jtarget = 26'd20; tick(); clear_inputs(); bump();
      jump = 1; branch = 1; jtarget = 26'h3FFFF40; imm = 16'd3; tick(); clear_inputs(); bump();
      n_checks++; if (pc !== 8'h40) begin n_fail++; $display("FAIL jb_pc got %0h exp 40", pc); end
      n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("FAIL jb_cnt got %0d exp %0d", redirect_cnt, exp_cnt); end
      jump = 1; jtarget = 26'd20; tick(); clear_inputs(); bump();
      stall = 1; jump = 1; branch = 1; jtarget = 26'h3FFFF40; imm = 16'd3; tick(); clear_inputs();
      n_checks++; if (pc !== 8'd20) begin n_fail++; $display("FAIL stall_pc got %0d exp 20", pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stall_flush got %b exp 0", flush); end
      n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b exp 1", pc_valid); end
      n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt got %0d exp %0d", redirect_cnt, exp_cnt); end
   endtask

   task automatic test_halt();
      jump = 1; jtarget = 26'd30; tick(); clear_inputs(); bump();
      halt = 1; jump = 1; jtarget = 26'd99; tick(); clear_inputs();
      n_checks++; if (pc !== 8'd30) begin n_fail++; $display("FAIL halt_pc got %0d exp 30", pc); end
      n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b exp 0", pc_valid); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL halt_flush got %b exp 0", flush); end
      n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("FAIL halt_cnt got %0d exp %0d", redirect_cnt, exp_cnt); end
      halt = 1; resume = 1; tick(); clear_inputs();
      n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_both_valid got %b exp 0", pc_valid); end
      jump = 1; branch = 1; jtarget = 26'd77; imm = 16'd5; tick(); clear_inputs();
      n_checks++; if (pc !== 8'd30) begin n_fail++; $display("FAIL halt_ignore_pc got %0d exp 30", pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL halt_ignore_flush got %b exp 0", flush); end
      resume = 1; tick(); clear_inputs();
      n_checks++; if (pc !== 8'd30) begin n_fail++; $display("FAIL resume_pc got %0d exp 30", pc); end
      n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid got %b exp 1", pc_valid); end
      tick();
      n_checks++; if (pc !== 8'd31) begin n_fail++; $display("FAIL resume_next got %0d exp 31", pc); end
      resume = 1; tick(); clear_inputs();
      n_checks++; if (pc !== 8'd32) begin n_fail++; $display("FAIL resume_run_pc got %0d exp 32", pc); end
      n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL resume_run_valid got %b exp 1", pc_valid); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         jump = 1; jtarget = 26'(i); tick(); bump();
      end
      clear_inputs();
      n_checks++; if (redirect_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt got %0d exp 255", redirect_cnt); end
      n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_model got %0d exp %0d", redirect_cnt, exp_cnt); end
      n_checks++; if (pc !== 8'd43) begin n_fail++; $display("FAIL sat_pc got %0d exp 43", pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL sat_flush got %b exp 1", flush); end
      rst = 1; jump = 1; jtarget = 26'd9; tick(); rst = 0; clear_inputs(); exp_cnt = 8'd0;
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b exp 0", flush); end
      n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL rst_pc got %0d exp 0", pc); end
      n_checks++; if (redirect_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", redirect_cnt); end
      n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", pc_valid); end
      tick();
      n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL rst_boot_valid got %b exp 1", pc_valid); end
      n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL rst_boot_pc got %0d exp 0", pc); end
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_wrap();
      test_branch();
      test_jump_branch();
      test_halt();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
